regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: round-robin between two requesters (A, B)
// plus a clear sequence that sweeps zeros across every register index.
module regfile_wb_arbiter #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              a_valid,
  input  logic [IDX_W-1:0]  a_idx,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [IDX_W-1:0]  b_idx,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [0:0] PRIO_A = 1'b0;
  localparam logic [0:0] PRIO_B = 1'b1;

  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

  logic [0:0]        state_r;
  logic [0:0]        prio_r;
  logic              wr_en_r;
  logic [IDX_W-1:0]  wr_idx_r;
  logic [DATA_W-1:0] wr_data_r;
  logic              a_ready_s;
  logic              b_ready_s;

  // Grant logic: a pending or running clear blocks both requesters.
  always_comb begin
    a_ready_s = 1'b0;
    b_ready_s = 1'b0;
    if ((state_r == IDLE) && !clr_start) begin
      a_ready_s = a_valid && (!b_valid || (prio_r == PRIO_A));
      b_ready_s = b_valid && (!a_valid || (prio_r == PRIO_B));
    end else begin
      a_ready_s = 1'b0;
      b_ready_s = 1'b0;
    end
  end

  // State, priority and the registered write port.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r   <= IDLE;
      prio_r    <= PRIO_A;
      wr_en_r   <= 1'b0;
      wr_idx_r  <= {IDX_W{1'b0}};
      wr_data_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (clr_start) begin
            state_r   <= CLEAR;
            wr_en_r   <= 1'b1;
            wr_idx_r  <= {IDX_W{1'b0}};
            wr_data_r <= {DATA_W{1'b0}};
          end else if (a_ready_s) begin
            wr_en_r   <= 1'b1;
            wr_idx_r  <= a_idx;
            wr_data_r <= a_data;
            prio_r    <= PRIO_B;
          end else if (b_ready_s) begin
            wr_en_r   <= 1'b1;
            wr_idx_r  <= b_idx;
            wr_data_r <= b_data;
            prio_r    <= PRIO_A;
          end else begin
            wr_en_r   <= 1'b0;
          end
        end
        CLEAR: begin
          // Index already sits on the last register: the sweep is done.
          if (wr_idx_r == IDX_LAST) begin
            state_r   <= IDLE;
            wr_en_r   <= 1'b0;
          end else begin
            wr_en_r   <= 1'b1;
            wr_idx_r  <= wr_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            wr_data_r <= {DATA_W{1'b0}};
          end
        end
        default: begin
          state_r <= IDLE;
          wr_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign a_ready  = a_ready_s;
  assign b_ready  = b_ready_s;
  assign clr_busy = (state_r == CLEAR);
  assign wr_en    = wr_en_r;
  assign wr_idx   = wr_idx_r;
  assign wr_data  = wr_data_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter; a transaction-level model predicts
// grants, the write-port stream and the clear-busy window.
module tb_regfile_wb_arbiter;

  localparam int DW   = 8;
  localparam int IW   = 2;
  localparam int NREG = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          a_valid, b_valid, clr_start;
  logic [IW-1:0] a_idx, b_idx;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, clr_busy, wr_en;
  logic [IW-1:0] wr_idx;
  logic [DW-1:0] wr_data;

  always #5 CLK = ~CLK;

  regfile_wb_arbiter #(.DATA_W(DW), .IDX_W(IW)) dut (
    .CLK(CLK), .RST(RST),
    .a_valid(a_valid), .a_idx(a_idx), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_idx(b_idx), .b_data(b_data), .b_ready(b_ready),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data)
  );

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } wr_t;

  int            vectors = 0;
  int            miscompares = 0;
  wr_t           q[$];
  int            busy_left;
  bit            prio_b;
  bit            m_en;
  logic [IW-1:0] m_idx;
  logic [DW-1:0] m_data;
  bit            m_a_rdy, m_b_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    busy_left = 0;
    prio_b    = 1'b0;
    m_en      = 1'b0;
    m_idx     = '0;
    m_data    = '0;
  endtask

  task automatic model_ready();
    if (busy_left > 0 || clr_start) begin
      m_a_rdy = 1'b0;
      m_b_rdy = 1'b0;
    end else if (a_valid && b_valid) begin
      m_a_rdy = !prio_b;
      m_b_rdy = prio_b;
    end else begin
      m_a_rdy = a_valid;
      m_b_rdy = b_valid;
    end
  endtask

  // Advance the model by one rising edge using the grants seen before it.
  task automatic model_edge();
    wr_t w;
    if (busy_left > 0) begin
      busy_left--;
    end else if (clr_start) begin
      for (int i = 0; i < NREG; i++) begin
        w.idx  = i[IW-1:0];
        w.data = '0;
        q.push_back(w);
      end
      busy_left = NREG;
    end else if (m_a_rdy) begin
      w.idx = a_idx; w.data = a_data; q.push_back(w); prio_b = 1'b1;
    end else if (m_b_rdy) begin
      w.idx = b_idx; w.data = b_data; q.push_back(w); prio_b = 1'b0;
    end
    if (q.size() > 0) begin
      w = q.pop_front();
      m_en = 1'b1; m_idx = w.idx; m_data = w.data;
    end else begin
      m_en = 1'b0;
    end
  endtask

  task automatic cycle(input logic av, input logic [IW-1:0] ai, input logic [DW-1:0] ad,
                       input logic bv, input logic [IW-1:0] bi, input logic [DW-1:0] bd,
                       input logic cs);
    @(negedge CLK);
    a_valid = av; a_idx = ai; a_data = ad;
    b_valid = bv; b_idx = bi; b_data = bd;
    clr_start = cs;
    #1;
    model_ready();
    check("a_ready",  a_ready,  m_a_rdy);
    check("b_ready",  b_ready,  m_b_rdy);
    check("excl_rdy", a_ready & b_ready, 1'b0);
    check("wr_en",    wr_en,    m_en);
    check("wr_idx",   wr_idx,   m_idx);
    check("wr_data",  wr_data,  m_data);
    check("clr_busy", clr_busy, busy_left > 0);
    @(posedge CLK);
    if (RST) model_edge();
    else model_reset();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic reset_pulse();
    @(negedge CLK);
    a_valid = 1'b0; b_valid = 1'b0; clr_start = 1'b0;
    RST = 1'b0;
    #1;
    check("rst_wr_en",  wr_en,    1'b0);
    check("rst_busy",   clr_busy, 1'b0);
    check("rst_wr_idx", wr_idx,   0);
    check("rst_wr_dat", wr_data,  0);
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    RST = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; clr_start = 1'b0;
    a_idx = '0; b_idx = '0; a_data = '0; b_data = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    // Readies stay combinational while reset is held.
    @(negedge CLK);
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    check("rst_a_rdy", a_ready, 1'b1);
    check("rst_b_rdy", b_ready, 1'b0);
    check("rst_en0",   wr_en,   1'b0);
    check("rst_bsy0",  clr_busy, 1'b0);
    a_valid = 1'b0; b_valid = 1'b0;
    RST = 1'b1;

    // Single A write.
    cycle(1'b1, 2'd2, 8'h5A, 1'b0, '0, '0, 1'b0);
    #1;
    check("single_en",   wr_en,   1'b1);
    check("single_idx",  wr_idx,  2);
    check("single_data", wr_data, 8'h5A);
    idle(2);

    // Contention: prio is B after the A transfer above; reset to get A first.
    reset_pulse();
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b0);
    idle(2);

    // Clear vs. request in the same cycle, A held through the clear.
    for (int i = 0; i < NREG + 2; i++) cycle(1'b1, 2'd2, 8'hC3, 1'b0, '0, '0, i == 0);
    idle(2);

    // Same index back to back.
    cycle(1'b1, 2'd0, 8'h01, 1'b0, '0, '0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 2'd0, 8'h02, 1'b0);
    idle(2);

    // clr_start held through the whole clear restarts it after one IDLE edge.
    for (int i = 0; i < 2 * NREG + 3; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    idle(NREG + 2);

    // Reset mid-clear with wr_idx = 1.
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    idle(1);
    @(negedge CLK);
    check("mid_idx", wr_idx, 1);
    reset_pulse();
    idle(NREG + 2);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        reset_pulse();
      end else begin
        cycle($urandom_range(0, 1), IW'($urandom), DW'($urandom),
              $urandom_range(0, 1), IW'($urandom), DW'($urandom),
              $urandom_range(0, 11) == 0);
      end
    end
    idle(NREG + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
